// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and line idle level.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_core_if.sv
// Write-side handshake between the peripheral register block and the TX core.
interface uart_tx_if;
    import uart_pkg::*;

    logic                      wr_uart;
    logic [UART_DATA_BITS-1:0] w_data;
    logic                      tx_full;
    logic                      tx_empty;
    logic                      tx_busy;

    // register block side
    modport master (
        output wr_uart, w_data,
        input  tx_full, tx_empty, tx_busy
    );

    // transmitter side
    modport slave (
        input  wr_uart, w_data,
        output tx_full, tx_empty, tx_busy
    );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty flags.
// The head entry is visible on r_data whenever empty is low.
module uart_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] w_data,
    input  logic          rd,
    output logic [DW-1:0] r_data,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_n;
    logic          wr_en;
    logic          rd_en;

    // A full FIFO drops writes even when a pop frees a slot on the same edge.
    assign wr_en  = wr && !full;
    assign rd_en  = rd && !empty;
    assign r_data = mem[rd_ptr];

    // Next occupancy; a simultaneous write and pop cancel out.
    always_comb begin
        count_n = count;
        case ({wr_en, rd_en})
            2'b10:   count_n = count + (AW + 1)'(1);
            2'b01:   count_n = count - (AW + 1)'(1);
            default: count_n = count;
        endcase
    end

    // Pointers, count and flags; flags are derived from the next count so they are flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count_n;
            full  <= (count_n == FULL_CNT);
            empty <= (count_n == '0);
        end
    end

    // Storage needs no reset: resetting the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= w_data;
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: buffers bytes in a FIFO and sends them as 8N1 frames.
// tx comes straight from a flop, so nothing on the inputs reaches the pin combinationally.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 4
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);

    tx_state_t                 state, state_n;
    logic [BW-1:0]             baud, baud_n;
    logic [IW-1:0]             bit_idx, bit_idx_n;
    logic [UART_DATA_BITS-1:0] shift, shift_n;
    logic                      tx_n;
    logic                      pop;
    logic [UART_DATA_BITS-1:0] head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      bit_done;

    uart_fifo #(
        .DW (UART_DATA_BITS),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr     (bus.wr_uart),
        .w_data (bus.w_data),
        .rd     (pop),
        .r_data (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign bus.tx_full  = fifo_full;
    assign bus.tx_empty = fifo_empty;
    assign bus.tx_busy  = (state != IDLE);
    assign bit_done     = (baud == BAUD_LAST);

    // State, datapath and line registers; reset forces the line idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= UART_IDLE_LEVEL;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
        end
    end

    // Frame sequencing: each state holds its line level for one bit time,
    // and STOP chains straight into the next START when data is waiting.
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                tx_n = UART_IDLE_LEVEL;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    tx_n    = 1'b0;
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_n    = '0;
                    bit_idx_n = '0;
                    tx_n      = shift[0];
                    state_n   = DATA;
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_n = '0;
                    if (bit_idx == BIT_LAST) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        shift_n   = shift >> 1;
                        tx_n      = shift[1];
                        bit_idx_n = bit_idx + IW'(1);
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_n = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        tx_n    = 1'b0;
                        state_n = START;
                    end else begin
                        tx_n    = UART_IDLE_LEVEL;
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud + BW'(1);
                end
            end
            default: begin
                tx_n    = UART_IDLE_LEVEL;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Transmit half of the UART core that sits behind the memory-mapped UART peripheral register block. It accepts bytes over the `wr_uart` / `w_data` / `tx_full` handshake driven by that block and buffers them in a small FIFO. It serialises them onto the `tx` pin as 8N1 frames (start bit, 8 data bits LSB first, one stop bit) at a fixed baud set by a clock divider. It is the transmitter counterpart of the peripheral's write path.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit; legal range ≥ 2.
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW entries.

Ports:
- `clk` input 1: system clock; all state on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `wr_uart` input 1: write strobe; the byte is accepted on any edge where `wr_uart`=1 and `tx_full`=0.
- `w_data` input 8: byte to enqueue; sampled with `wr_uart`.
- `tx_full` output 1: FIFO holds 2^FIFO_AW entries; registered.
- `tx_empty` output 1: FIFO holds 0 entries; registered.
- `tx_busy` output 1: FSM is not in IDLE.
- `tx` output 1: serial line; idles high.

## Operation
- Reset values: `tx`=1, `tx_full`=0, `tx_empty`=1, `tx_busy`=0. The FIFO pointers, count, baud counter and bit index are all 0, and the FSM is in IDLE.
- Reset asserted mid-frame aborts the frame immediately: `tx` goes to 1 asynchronously and FIFO contents are discarded.
- FIFO:
  - Show-ahead, with pointers that wrap modulo 2^FIFO_AW and a count width of FIFO_AW+1.
  - A write when `tx_full`=1 is ignored silently, even if a pop occurs on the same edge.
  - A pop occurs only when the FIFO is non-empty.
  - A simultaneous accepted write and pop leaves the count unchanged.
- FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, drive `tx`=0, clear the baud counter, and go to START.
  - START: hold `tx`=0 for CLKS_PER_BIT cycles, then drive `tx`=shift[0] with bit index 0, and go to DATA.
  - DATA: each bit is held for CLKS_PER_BIT cycles, then the register shifts right. After bit index 7 completes, drive `tx`=1 and go to STOP.
  - STOP: hold `tx`=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop, drive `tx`=0, and go to START with no idle gap. Otherwise go to IDLE.
- The baud counter counts 0 to CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Its width is $clog2(CLKS_PER_BIT).
- `tx` is driven from a flop; there is no combinational path from the inputs to `tx`.

## Timing
- Write accepted at edge E0: `tx_empty` falls after E0.
- If IDLE at E1: pop at E1 and `tx` falls after E1, so the latency from write to start bit is 1 cycle.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames have a period of exactly 10·CLKS_PER_BIT.
- `tx_full` asserts after the edge that writes the 2^FIFO_AW-th entry. It deasserts after the next pop edge.
- `tx_busy` rises with the start bit and falls after the last stop-bit cycle when the FIFO is empty.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP.
  - Constant `UART_DATA_BITS`=8.
  - Idle line level constant.
- Sub-module `uart_fifo`: synchronous show-ahead FIFO, parameterised by width and address width, with async reset. It is reused by the future receive path.
- The FSM, baud counter and shift register live in `uart_tx_core`.

## Test plan
Bench uses CLKS_PER_BIT=4 and FIFO_AW=2.
- Reset then idle 50 cycles -> `tx`=1, `tx_empty`=1, `tx_full`=0, `tx_busy`=0 throughout.
- Write 0xA5 once -> `tx` goes low 1 cycle later, then over 40 cycles the bit pattern is 0, 1,0,1,0,0,1,0,1, 1, each bit lasting 4 cycles. `tx_busy` then falls.
- Write 0x00, 0xFF, 0x3C on consecutive cycles -> three frames with no gap between them, total 120 cycles. Sampled mid-bit, the bytes decode as 0x00, 0xFF, 0x3C.
- Write 5 bytes on consecutive cycles starting from IDLE:
  - `tx_full` asserts after the 5th write, since the first byte was popped.
  - A 6th write while full is dropped.
  - Exactly 5 frames are emitted.
- While full, hold `wr_uart`=1 on the cycle the STOP→START pop occurs -> write ignored and count drops to 3.
- Assert `rst` during DATA bit 3 of 0x55 with 2 bytes queued -> `tx`=1 immediately, `tx_empty`=1, and no further frames after release.
